reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Central reset controller that turns the global synchronous reset and run-time reset requests into an ordered, staggered set of per-stage reset outputs. After power-on or a request, it holds all stages in reset for a programmable time, then releases them one by one with a fixed gap. Once fully released, it keeps every stage deasserted until the next reset or request. Downstream blocks use `stage_rst[k]` as their local reset; the "stays released forever" guarantee is a checked invariant.

## Interface
- `NUM_STAGES`, default 3: number of reset outputs, legal range 1..8.
- `HOLD_CYCLES`, default 3: cycles all stages stay asserted after the reset source drops, minimum 1.
- `GAP_CYCLES`, default 2: cycles between consecutive stage releases, minimum 1.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `sw_req`  in  1  software reset request, level-sensitive.
- `wdt_req`  in  1  watchdog reset request, level-sensitive.
- `stage_rst`  out  NUM_STAGES  per-stage reset, active-high, registered.
- `busy`  out  1  high while any stage is asserted or the release is in progress.
- `done`  out  1  one-cycle pulse when the last stage is released.
- `cause`  out  2  last reset source: bit0 = sw, bit1 = wdt, 00 = power-on reset.

## Operation
- States are ASSERT, RELEASE and RUN. A single counter `cnt` (`CNT_W = $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1)`) and a stage index `idx` (`$clog2(NUM_STAGES+1)` bits) drive them.
- **Reset** (`rst=1` at an edge):
  - state = ASSERT, `cnt=0`, `idx=0`.
  - `stage_rst` = all ones, `busy=1`, `done=0`, `cause=00`.
- **ASSERT**:
  - While `sw_req` or `wdt_req` is high, `cnt` is held at 0.
  - Otherwise `cnt` increments each cycle.
  - At the edge where `cnt==HOLD_CYCLES-1`: clear `stage_rst[0]`, set `cnt=0` and `idx=1`.
  - Go to RELEASE, or to RUN if `NUM_STAGES==1`.
- **RELEASE**:
  - `cnt` increments each cycle.
  - At `cnt==GAP_CYCLES-1`: clear `stage_rst[idx]`, increment `idx`, set `cnt=0`.
  - After the last stage is cleared, go to RUN.
- **RUN**: `stage_rst` = 0, `busy=0`. Outputs do not change until `rst` or a request arrives.
- **Request in any state** (`sw_req|wdt_req` high at an edge, `rst=0`):
  - state = ASSERT, `stage_rst` = all ones, `cnt=0`, `idx=0`, `busy=1`.
  - `cause` = {`wdt_req`, `sw_req`} as sampled at that edge.
  - A request arriving mid-RELEASE aborts the release and reasserts every stage on the next edge.
- `rst` has priority over requests. A request arriving at the same edge as `rst` is ignored and `cause` = 00.
- `done` is registered high for exactly one cycle following the edge that clears the last stage. It is never high in the same cycle as `busy`.
- Invariants (to be asserted in the bench):
  - Ordering: `stage_rst[k]` is never 0 while `stage_rst[k-1]` is 1.
  - Stability: in RUN, `stage_rst` stays 0 on every later edge until `rst` or a request occurs.

## Timing
- Number edges from 1, starting at the first edge where `rst=0` and no request is high.
- `stage_rst[k]` falls at edge `HOLD_CYCLES + k*GAP_CYCLES`.
- `busy` and `done` change at edge `HOLD_CYCLES + (NUM_STAGES-1)*GAP_CYCLES`.
- Defaults (3 stages, hold 3, gap 2): stages fall at edges 3, 5 and 7; `done` is high during the cycle after edge 7.
- Request to full reassertion latency: 1 edge.
- A request held for M cycles extends the hold phase by M cycles.
- No combinational paths from inputs to outputs.

## Structure
- Package `reset_seq_pkg` contains:
  - `typedef enum logic [1:0] {ASSERT, RELEASE, RUN} rst_state_t`.
  - Cause constants `CAUSE_POR=2'b00`, `CAUSE_SW=2'b01`, `CAUSE_WDT=2'b10`.
- Sub-module `reset_seq_timer`: a loadable up-counter with a terminal-count compare. Its inputs are `clr`, `en` and `limit`; its output is `tc`.
- The FSM, stage register and cause register live in the top module.

## Test plan
- **Power-on**: `rst` high for 3 cycles, then low, with defaults → `stage_rst` goes 111→110 at edge 3, →100 at edge 5, →000 at edge 7. `done` pulses once and `cause=00`.
- **Stability**: after release, run 20 more cycles with no requests → `stage_rst=000` and `busy=0` on every edge.
- **Mid-release abort**: `sw_req` pulsed for 1 cycle at edge 4 → `stage_rst=111` at edge 5 and `cause=01`. The stages then release 3, 5 and 7 edges after the request drops.
- **Both requests, held**: `wdt_req` and `sw_req` held high for 4 cycles in RUN → `stage_rst=111` the whole time and `cause=11`. Release starts counting at the first edge with both low.
- **Reset wins**: `rst` and `wdt_req` high at the same edge → `cause=00` and the normal power-on sequence follows.
- **Corner parameters**: `NUM_STAGES=1`, `HOLD_CYCLES=1` → the single stage falls at edge 1 and `done` is high in the following cycle.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared state encoding and reset-cause codes for the reset sequencer.
package reset_seq_pkg;
  typedef enum logic [1:0] {ASSERT, RELEASE, RUN} rst_state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;
endpackage

// File: rtl/reset_seq_timer.sv
// Clearable up-counter; tc flags the enabled cycle in which the count equals limit.
module reset_seq_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr)     cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end

  assign tc = en && (cnt == limit);
endmodule

// File: rtl/reset_sequencer.sv
// Staggered per-stage reset release: hold all stages, then drop them one at a time.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_req,
  input  logic                  wdt_req,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            cause
);
  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(NUM_STAGES + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  rst_state_t            state, state_n;
  logic [NUM_STAGES-1:0] stage_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic                  busy_n, done_n;
  logic [1:0]            cause_n;
  logic                  clr, en, tc;
  logic [CNT_W-1:0]      limit;
  logic                  req;

  assign req = sw_req | wdt_req;

  reset_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .clr   (clr | rst),
    .en    (en),
    .limit (limit),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ASSERT;
      stage_rst <= '1;
      idx       <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      cause     <= CAUSE_POR;
    end else begin
      state     <= state_n;
      stage_rst <= stage_n;
      idx       <= idx_n;
      busy      <= busy_n;
      done      <= done_n;
      cause     <= cause_n;
    end
  end

  // Stages release from bit 0 upward, so each release is a left shift of the mask.
  always_comb begin
    state_n = state;
    stage_n = stage_rst;
    idx_n   = idx;
    busy_n  = busy;
    done_n  = 1'b0;
    cause_n = cause;
    clr     = 1'b0;
    en      = 1'b0;
    limit   = HOLD_LIM;
    if (req) begin
      state_n = ASSERT;
      stage_n = '1;
      idx_n   = '0;
      busy_n  = 1'b1;
      cause_n = (sw_req ? CAUSE_SW : CAUSE_POR) | (wdt_req ? CAUSE_WDT : CAUSE_POR);
      clr     = 1'b1;
    end else begin
      case (state)
        ASSERT: begin
          en    = 1'b1;
          limit = HOLD_LIM;
          if (tc) begin
            stage_n = stage_rst << 1;
            clr     = 1'b1;
            idx_n   = IDX_W'(1);
            if (NUM_STAGES == 1) begin
              state_n = RUN;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              state_n = RELEASE;
            end
          end
        end
        RELEASE: begin
          en    = 1'b1;
          limit = GAP_LIM;
          if (tc) begin
            stage_n = stage_rst << 1;
            clr     = 1'b1;
            idx_n   = idx + 1'b1;
            if (idx == LAST_IDX) begin
              state_n = RUN;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end
          end
        end
        RUN:     ;
        default: state_n = ASSERT;
      endcase
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: two sequencer configurations against an edge-count reference model.
module tb_reset_sequencer;
  typedef struct {
    logic [7:0] stage;
    logic       busy;
    logic       done;
    logic [1:0] cause;
    logic       quiet;
  } exp_t;

  localparam int N0 = 3, H0 = 3, G0 = 2;
  localparam int N1 = 1, H1 = 1, G1 = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_req = 1'b0;
  logic       wdt_req = 1'b0;
  logic [2:0] stage0;
  logic [0:0] stage1;
  logic       busy0, busy1, done0, done1;
  logic [1:0] cause0, cause1;

  int pass_cnt = 0;
  int total_cnt = 0;

  exp_t q0[$];
  exp_t q1[$];

  int         nst[2] = '{N0, N1};
  int         hld[2] = '{H0, H1};
  int         gap[2] = '{G0, G1};
  int         quiet_edges[2] = '{0, 0};
  logic [1:0] m_cause[2] = '{2'b00, 2'b00};
  logic       prev_run[2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_STAGES(N0), .HOLD_CYCLES(H0), .GAP_CYCLES(G0)) u_dut0 (
    .clk(clk), .rst(rst), .sw_req(sw_req), .wdt_req(wdt_req),
    .stage_rst(stage0), .busy(busy0), .done(done0), .cause(cause0)
  );

  reset_sequencer #(.NUM_STAGES(N1), .HOLD_CYCLES(H1), .GAP_CYCLES(G1)) u_dut1 (
    .clk(clk), .rst(rst), .sw_req(sw_req), .wdt_req(wdt_req),
    .stage_rst(stage1), .busy(busy1), .done(done1), .cause(cause1)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
  endtask

  // Reference: stage k is released once the number of consecutive quiet edges
  // reaches HOLD + k*GAP; any reset source restarts the count.
  function automatic exp_t model(input int i, input logic r, input logic s, input logic w);
    exp_t x;
    int   last;
    if (r) begin
      quiet_edges[i] = 0;
      m_cause[i]     = 2'b00;
    end else if (s || w) begin
      quiet_edges[i] = 0;
      m_cause[i]     = {w, s};
    end else if (quiet_edges[i] < 1000) begin
      quiet_edges[i]++;
    end
    last    = hld[i] + (nst[i] - 1) * gap[i];
    x.stage = 8'h00;
    for (int k = 0; k < nst[i]; k++)
      x.stage[k] = (quiet_edges[i] < hld[i] + k * gap[i]);
    x.busy  = (quiet_edges[i] < last);
    x.done  = (quiet_edges[i] == last);
    x.cause = m_cause[i];
    x.quiet = !(r || s || w);
    return x;
  endfunction

  task automatic step(input logic r, input logic s, input logic w);
    rst     = r;
    sw_req  = s;
    wdt_req = w;
    q0.push_back(model(0, r, s, w));
    q1.push_back(model(1, r, s, w));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_dut(input int i, input exp_t x, input logic [7:0] st,
                           input logic b, input logic d, input logic [1:0] c);
    logic ok;
    string tag;
    tag = (i == 0) ? "cfg0" : "cfg1";
    chk({tag, " stage_rst"}, st, x.stage);
    chk({tag, " busy"}, {7'd0, b}, {7'd0, x.busy});
    chk({tag, " done"}, {7'd0, d}, {7'd0, x.done});
    chk({tag, " cause"}, {6'd0, c}, {6'd0, x.cause});
    ok = 1'b1;
    for (int k = 1; k < nst[i]; k++)
      if (st[k] == 1'b0 && st[k-1] == 1'b1) ok = 1'b0;
    chk({tag, " ordering"}, {7'd0, ok}, 8'd1);
    if (prev_run[i] && x.quiet) chk({tag, " stability"}, st, 8'd0);
    prev_run[i] = (st == 8'd0) && !b;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        x = q0.pop_front();
        check_dut(0, x, {5'd0, stage0}, busy0, done0, cause0);
      end
      if (q1.size() > 0) begin
        x = q1.pop_front();
        check_dut(1, x, {7'd0, stage1}, busy1, done1, cause1);
      end
    end
  end

  initial begin : stimulus
    // Power-on then a long quiet stretch covers release and stability.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(28);
    // Software request in the middle of the release.
    step(1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 1'b1, 1'b0);
    idle(10);
    // Both requests held for four cycles while running.
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 1'b1);
    idle(10);
    // Reset and watchdog together: reset wins.
    step(1'b1, 1'b0, 1'b1);
    idle(10);
    // Randomised mix of resets and requests.
    for (int j = 0; j < 400; j++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0);
    idle(12);
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard drained", 8'(q0.size() + q1.size()), 8'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
